// File: rtl/dr_pkg.sv
// Shared definitions for the dual-rail sink: rail indices, the
// per-bit rail bundle type and the sink FSM state encoding.
package dr_pkg;

    localparam int RAIL_NUM = 2;
    localparam int RAIL_T   = 1;
    localparam int RAIL_F   = 0;

    typedef logic [RAIL_NUM-1:0] dr_bit_t;

    typedef enum logic [1:0] {
        WAIT_DATA = 2'd0,
        OFFER     = 2'd1,
        WAIT_NULL = 2'd2
    } dr_sink_state_e;

endpackage

// File: rtl/dr_sync.sv
// N-stage flop synchronizer on a W-bit vector, sync active-low reset to 0.
// Ports: clk_i, rst_ni, d_i (async input vector), q_o (synchronized vector).
module dr_sync #(
    parameter int W      = 2,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0][W-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dr_sink_sync.sv
// Dual-rail four-phase receiver: synchronizes rails, detects completion and
// spacer, decodes the word and offers it on a valid/ready port, then drives
// the link acknowledge through the data and spacer phases.
// Ports: clk_i, rst_ni (sync, active-low), in (dual-rail data), ack_o,
//   data_o, valid_o, ready_i, err_o (sticky 11-code flag).
// Option: define DR_SINK_ERR_EN to flag both-rails-high codes on err_o and
//   treat them as incomplete; otherwise err_o is 0 and 11 decodes as 1.
module dr_sink_sync
    import dr_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  dr_bit_t [WIDTH-1:0]  in,
    output logic                 ack_o,
    output logic [WIDTH-1:0]     data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 err_o
);

    dr_bit_t [WIDTH-1:0] s;

    dr_sync #(
        .W      (WIDTH*RAIL_NUM),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (in),
        .q_o    (s)
    );

    logic             complete;
    logic             is_null;
    logic [WIDTH-1:0] decoded;
    logic [WIDTH-1:0] bit_done;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
`ifdef DR_SINK_ERR_EN
            // An 11 bit is illegal and must not complete the word.
            bit_done[i] = s[i][RAIL_T] ^ s[i][RAIL_F];
`else
            bit_done[i] = s[i][RAIL_T] | s[i][RAIL_F];
`endif
            decoded[i] = s[i][RAIL_T];
        end
    end

    assign complete = &bit_done;
    assign is_null  = ~|s;

    dr_sink_state_e   state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ack_q, ack_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ack_d   = ack_q;
        unique case (state_q)
            WAIT_DATA: begin
                if (complete) begin
                    data_d  = decoded;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                // Ack is held back until downstream takes the word.
                if (ready_i) begin
                    ack_d   = 1'b1;
                    state_d = WAIT_NULL;
                end
            end
            WAIT_NULL: begin
                if (is_null) begin
                    ack_d   = 1'b0;
                    state_d = WAIT_DATA;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = WAIT_DATA;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= WAIT_DATA;
            data_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

`ifdef DR_SINK_ERR_EN
    logic both_hi;
    logic err_q;

    always_comb begin
        both_hi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            both_hi = both_hi | (s[i][RAIL_T] & s[i][RAIL_F]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (both_hi) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign ack_o   = ack_q;
    assign data_o  = data_q;
    assign valid_o = (state_q == OFFER);

endmodule
